acc_bank: RTL and testbench

ACC_BANK -- requirements
Module: acc_bank

---
 rtl/acc_bank.sv | 101 ++++++++++
 tb/tb_acc_bank.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_bank.sv
// Multi-channel signed accumulator bank: sums TERMS input vectors per channel and
// hands each result out through a one-deep valid/ready output register.
module acc_bank #(
  parameter int IN_W     = 32,
  parameter int ACC_W    = 40,
  parameter int N_CH     = 4,
  parameter int TERMS    = 8,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [N_CH*IN_W-1:0]    i_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [N_CH*ACC_W-1:0]   o_data,
  output logic [N_CH-1:0]         o_overflow
);

  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [N_CH-1:0][ACC_W-1:0] acc_r;
  logic [N_CH-1:0][ACC_W-1:0] sum_s;
  logic [N_CH-1:0]            ovf_s;
  logic [N_CH-1:0]            sticky_r;
  logic [CNT_W-1:0]           cnt_r;
  logic                       last_s;
  logic                       in_xfer_s;
  logic                       out_xfer_s;
  logic                       load_s;

  function automatic logic [ACC_W-1:0] sext(input logic [IN_W-1:0] t);
    return ACC_W'($signed(t));
  endfunction

  // Returns {overflow, result}; result is clamped or wrapped depending on SATURATE.
  function automatic logic [ACC_W:0] add_term(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] s;
    logic             ov;
    s  = a + b;
    ov = (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    if (ov && (SATURATE != 0)) begin
      s = a[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
    return {ov, s};
  endfunction

  assign last_s     = (cnt_r == CNT_W'(TERMS - 1));
  // Only the final term can stall: it needs the output register free or draining.
  assign o_ready    = !(last_s && o_valid && !i_ready);
  assign in_xfer_s  = i_valid && o_ready;
  assign out_xfer_s = o_valid && i_ready;
  assign load_s     = in_xfer_s && last_s && !i_clear;

  // Per-channel next sums and overflow detection
  always_comb begin
    sum_s = '0;
    ovf_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      {ovf_s[k], sum_s[k]} = add_term(acc_r[k], sext(i_data[k*IN_W +: IN_W]));
    end
  end

  // Accumulators, term counter and sticky overflow flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_r    <= '0;
      cnt_r    <= '0;
      sticky_r <= '0;
    end else if (i_clear || (in_xfer_s && last_s)) begin
      acc_r    <= '0;
      cnt_r    <= '0;
      sticky_r <= '0;
    end else if (in_xfer_s) begin
      acc_r    <= sum_s;
      cnt_r    <= cnt_r + CNT_W'(1);
      sticky_r <= sticky_r | ovf_s;
    end
  end

  // Output result register: load on the final term, drop valid once consumed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_overflow <= '0;
    end else if (load_s) begin
      o_valid    <= 1'b1;
      o_data     <= sum_s;
      o_overflow <= sticky_r | ovf_s;
    end else if (out_xfer_s) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_bank.sv
// Table-driven scoreboard bench for acc_bank: default 40-bit instance plus 34-bit
// saturating/wrapping instances sharing stimulus, and a TERMS=1 instance.
module tb_acc_bank;

  typedef struct {
    logic [159:0] d40;
    logic [3:0]   o40;
    logic [135:0] ds;
    logic [3:0]   os;
    logic [135:0] dw;
    logic [3:0]   ow;
  } exp_t;

  typedef struct {
    logic [127:0] term;
    exp_t         exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         i_clear = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b1;
  logic [127:0] i_data = '0;
  logic         o_ready, o_valid;
  logic [159:0] o_data;
  logic [3:0]   o_overflow;
  logic         s_ready, s_valid, w_ready, w_valid;
  logic [135:0] s_data, w_data;
  logic [3:0]   s_ovf, w_ovf;
  logic         t1_valid = 1'b0;
  logic [127:0] t1_data = '0;
  logic         t1_ready, t1_ovalid;
  logic [159:0] t1_odata;
  logic [3:0]   t1_ovf;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t none_e;
  vec_t tbl[4];

  always #5 clk = ~clk;

  acc_bank #(.IN_W(32), .ACC_W(40), .N_CH(4), .TERMS(8), .SATURATE(1)) dut (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_overflow(o_overflow));

  acc_bank #(.IN_W(32), .ACC_W(34), .N_CH(4), .TERMS(8), .SATURATE(1)) dut_s34 (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(s_ready),
    .i_data(i_data), .o_valid(s_valid), .i_ready(i_ready), .o_data(s_data), .o_overflow(s_ovf));

  acc_bank #(.IN_W(32), .ACC_W(34), .N_CH(4), .TERMS(8), .SATURATE(0)) dut_w34 (
    .clk(clk), .reset_n(reset_n), .i_clear(i_clear), .i_valid(i_valid), .o_ready(w_ready),
    .i_data(i_data), .o_valid(w_valid), .i_ready(i_ready), .o_data(w_data), .o_overflow(w_ovf));

  acc_bank #(.IN_W(32), .ACC_W(40), .N_CH(4), .TERMS(1), .SATURATE(1)) dut_t1 (
    .clk(clk), .reset_n(reset_n), .i_clear(1'b0), .i_valid(t1_valid), .o_ready(t1_ready),
    .i_data(t1_data), .o_valid(t1_ovalid), .i_ready(1'b1), .o_data(t1_odata), .o_overflow(t1_ovf));

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: pop and compare whenever an output transfer is about to happen
  always begin
    @(negedge clk);
    #2;
    if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 256'd1, 256'd0);
      end else begin
        mon_e = sb.pop_front();
        check("res40_data", o_data, mon_e.d40);
        check("res40_ovf", o_overflow, mon_e.o40);
        check("sat34_data", s_data, mon_e.ds);
        check("sat34_ovf", s_ovf, mon_e.os);
        check("wrap34_data", w_data, mon_e.dw);
        check("wrap34_ovf", w_ovf, mon_e.ow);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send(input logic [127:0] d, input exp_t e, input bit push);
    int g;
    g = 0;
    i_valid = 1'b1;
    i_data  = d;
    #1;
    while (!o_ready && g < 200) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 200) check("ready_timeout", 256'd0, 256'd1);
    if (push) sb.push_back(e);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic send_batch(input logic [127:0] d, input exp_t e);
    for (int i = 0; i < 8; i++) send(d, e, i == 7);
  endtask

  function automatic exp_t uniform(input logic [39:0] v);
    exp_t e;
    e.d40 = {4{v}};
    e.o40 = 4'b0000;
    e.ds  = {4{v[33:0]}};
    e.os  = 4'b0000;
    e.dw  = {4{v[33:0]}};
    e.ow  = 4'b0000;
    return e;
  endfunction

  initial begin
    none_e = uniform(40'd0);
    tbl[0].term = {4{32'd1}};
    tbl[0].exp  = uniform(40'd8);
    tbl[1].term = {32'd0, 32'd0, 32'd0, 32'hFFFFFFFB};
    tbl[1].exp  = '{d40: {40'd0, 40'd0, 40'd0, 40'hFFFFFFFFD8}, o40: 4'b0000,
                    ds: {34'd0, 34'd0, 34'd0, 34'h3FFFFFFD8}, os: 4'b0000,
                    dw: {34'd0, 34'd0, 34'd0, 34'h3FFFFFFD8}, ow: 4'b0000};
    tbl[2].term = {32'h80000000, 32'd1000, 32'hFFFFFFFF, 32'd7};
    tbl[2].exp  = '{d40: {40'hFC00000000, 40'h1F40, 40'hFFFFFFFFF8, 40'h38}, o40: 4'b0000,
                    ds: {34'h200000000, 34'h1F40, 34'h3FFFFFFF8, 34'h38}, os: 4'b1000,
                    dw: {34'h000000000, 34'h1F40, 34'h3FFFFFFF8, 34'h38}, ow: 4'b1000};
    tbl[3].term = {32'd0, 32'd0, 32'd0, 32'h7FFFFFFF};
    tbl[3].exp  = '{d40: {40'd0, 40'd0, 40'd0, 40'h03FFFFFFF8}, o40: 4'b0000,
                    ds: {34'd0, 34'd0, 34'd0, 34'h1FFFFFFFF}, os: 4'b0001,
                    dw: {34'd0, 34'd0, 34'd0, 34'h3FFFFFFF8}, ow: 4'b0001};

    // reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_o_data", o_data, 160'd0);
    check("rst_o_overflow", o_overflow, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 check("rst_o_ready", o_ready, 1'b1);

    // TERMS=1: each accepted term comes out sign-extended
    @(negedge clk);
    t1_valid = 1'b1;
    t1_data  = {32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd7};
    @(negedge clk);
    t1_data  = {32'd0, 32'd0, 32'd0, 32'hFFFFFFFE};
    #1;
    check("t1_valid0", t1_ovalid, 1'b1);
    check("t1_data0", t1_odata, {40'hFFFFFFFFFF, 40'd5, 40'hFF80000000, 40'd7});
    @(negedge clk);
    t1_valid = 1'b0;
    #1 check("t1_data1", t1_odata, {40'd0, 40'd0, 40'd0, 40'hFFFFFFFFFE});
    @(negedge clk);
    #1 check("t1_idle", t1_ovalid, 1'b0);

    // table of full-batch vectors
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      send_batch(tbl[r].term, tbl[r].exp);
      #1 check("latency_valid", o_valid, 1'b1);
      @(negedge clk);
    end

    // backpressure: result A pending, batch B stalls on its last term
    i_ready = 1'b0;
    send_batch(tbl[0].term, tbl[0].exp);
    #1 check("bp_pending", o_valid, 1'b1);
    for (int i = 0; i < 7; i++) begin
      i_valid = 1'b1;
      i_data  = tbl[1].term;
      #1 check("bp_accept", o_ready, 1'b1);
      @(negedge clk);
    end
    i_valid = 1'b1;
    i_data  = tbl[1].term;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall", o_ready, 1'b0);
      check("bp_hold", o_data, tbl[0].exp.d40);
      @(negedge clk);
    end
    sb.push_back(tbl[1].exp);
    i_ready = 1'b1;
    #1 check("bp_release", o_ready, 1'b1);
    @(negedge clk);
    i_valid = 1'b0;
    #1 check("bp_second_valid", o_valid, 1'b1);
    @(negedge clk);

    // clear drops the partial sum and its own term
    for (int i = 0; i < 3; i++) send({4{32'd100}}, none_e, 1'b0);
    i_clear = 1'b1;
    i_valid = 1'b1;
    i_data  = {4{32'd100}};
    @(negedge clk);
    i_clear = 1'b0;
    i_valid = 1'b0;
    send_batch({4{32'd2}}, uniform(40'd16));
    @(negedge clk);

    // reset mid-operation discards pending result and partial sum
    i_ready = 1'b0;
    send_batch(tbl[2].term, tbl[2].exp);
    for (int i = 0; i < 5; i++) send({4{32'd3}}, none_e, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_o_valid", o_valid, 1'b0);
    check("midrst_o_data", o_data, 160'd0);
    check("midrst_o_overflow", o_overflow, 4'd0);
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 check("midrst_o_ready", o_ready, 1'b1);
    i_ready = 1'b1;
    @(negedge clk);
    send_batch({4{32'd3}}, uniform(40'd24));

    repeat (3) @(negedge clk);
    check("sb_drained", 256'(sb.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
